eeg_sram_port_sched: RTL and testbench

Round-robin scheduler that shares one single-port feature/weight SRAM among N_REQ datapath requesters (PE-array loaders, DMA, CPU config port). Each requester issues read/write beats over a valid/ready handshake, optionally grouped into locked bursts. Read data returns on a common bus with a per-requester one-hot valid after a fixed SRAM latency. The block sits between the PE-array control path and the SRAM macro wrapper.

---
 rtl/eeg_sram_port_sched_pkg.sv | 19 +
 rtl/eeg_rsp_tag_pipe.sv | 45 ++++
 rtl/eeg_sram_port_sched.sv | 129 ++++++++++++
 tb/tb_eeg_sram_port_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eeg_sram_port_sched_pkg.sv
// Shared constants and FSM encoding for the SRAM port scheduler and its
// read-response tag pipeline.
package eeg_sram_port_sched_pkg;

   localparam int DEF_N_REQ     = 4;
   localparam int DEF_AW        = 10;
   localparam int DEF_DW        = 32;
   localparam int DEF_RD_LAT    = 2;
   localparam int DEF_MAX_BURST = 16;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } sched_state_t;

endpackage

// File: rtl/eeg_rsp_tag_pipe.sv
// Fixed-latency shift pipeline carrying a valid bit and the one-hot tag of the
// requester whose read beat is travelling through the SRAM.
module eeg_rsp_tag_pipe
   import eeg_sram_port_sched_pkg::*;
#(
   parameter int N_TAG  = DEF_N_REQ,
   parameter int RD_LAT = DEF_RD_LAT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [N_TAG-1:0] in_tag,
   output logic             out_valid,
   output logic [N_TAG-1:0] out_tag,
   output logic             any_valid
);

   localparam int DEPTH = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                          (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

   logic [DEPTH-1:0] vld_q;
   logic [N_TAG-1:0] tag_q [DEPTH];

   // Reset drops every response still in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= in_valid;
         tag_q[0] <= in_valid ? in_tag : '0;
         for (int i = 1; i < DEPTH; i++) begin
            vld_q[i] <= vld_q[i-1];
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   assign out_valid = vld_q[DEPTH-1];
   assign out_tag   = tag_q[DEPTH-1];
   assign any_valid = |vld_q;

endmodule

// File: rtl/eeg_sram_port_sched.sv
// Round-robin scheduler sharing one single-port SRAM among N_REQ requesters,
// with locked bursts, forced release after MAX_BURST beats and tagged read returns.
module eeg_sram_port_sched
   import eeg_sram_port_sched_pkg::*;
#(
   parameter int N_REQ     = DEF_N_REQ,
   parameter int AW        = DEF_AW,
   parameter int DW        = DEF_DW,
   parameter int RD_LAT    = DEF_RD_LAT,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ-1:0]         req_we,
   input  logic [N_REQ-1:0]         req_last,
   input  logic [N_REQ*AW-1:0]      req_addr,
   input  logic [N_REQ*DW-1:0]      req_wdata,
   output logic [N_REQ-1:0]         req_ready,
   output logic [N_REQ-1:0]         rsp_valid,
   output logic [DW-1:0]            rsp_rdata,
   output logic                     mem_en,
   output logic                     mem_we,
   output logic [AW-1:0]            mem_addr,
   output logic [DW-1:0]            mem_wdata,
   input  logic [DW-1:0]            mem_rdata,
   output logic [$clog2(N_REQ)-1:0] owner,
   output logic                     busy
);

   localparam int PW = $clog2(N_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);

   sched_state_t   state, state_nxt;
   logic [PW-1:0]  ptr, ptr_nxt, owner_nxt;
   logic [CW-1:0]  beat_cnt, cnt_nxt, cnt_inc;
   logic [PW-1:0]  win, grant_idx;
   logic           win_found, grant_valid, accept, release_now;
   logic           pipe_valid, pipe_any;
   logic [N_REQ-1:0] pipe_tag;

   // Priority pair: lowest valid index at or above ptr wins, otherwise the
   // lowest valid index overall (wrap-around).
   always_comb begin
      win       = '0;
      win_found = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            win       = PW'(i);
            win_found = 1'b1;
         end
      end
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_valid[i] && (i >= int'(ptr))) begin
            win = PW'(i);
         end
      end
   end

   assign grant_idx   = (state == BURST) ? owner : win;
   assign grant_valid = (state == BURST) ? req_valid[owner] : win_found;
   assign accept      = grant_valid & rst_n;
   assign cnt_inc     = beat_cnt + 1'b1;
   assign release_now = req_last[grant_idx] || (cnt_inc == CW'(MAX_BURST));

   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   assign mem_en    = accept;
   assign mem_we    = accept & req_we[grant_idx];
   assign mem_addr  = accept ? req_addr[grant_idx*AW +: AW]  : '0;
   assign mem_wdata = accept ? req_wdata[grant_idx*DW +: DW] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         owner    <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         owner    <= owner_nxt;
         beat_cnt <= cnt_nxt;
      end
   end

   // beat_cnt is zero in IDLE, so the same increment/limit test covers the
   // first beat of a burst and every later one.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      owner_nxt = owner;
      cnt_nxt   = beat_cnt;
      if (accept) begin
         owner_nxt = grant_idx;
         if (release_now) begin
            state_nxt = IDLE;
            ptr_nxt   = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            cnt_nxt   = '0;
         end else begin
            state_nxt = BURST;
            cnt_nxt   = cnt_inc;
         end
      end
   end

   eeg_rsp_tag_pipe #(
      .N_TAG  (N_REQ),
      .RD_LAT (RD_LAT)
   ) u_rsp_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (accept & ~req_we[grant_idx]),
      .in_tag    (req_ready),
      .out_valid (pipe_valid),
      .out_tag   (pipe_tag),
      .any_valid (pipe_any)
   );

   assign rsp_valid = pipe_valid ? pipe_tag  : '0;
   assign rsp_rdata = pipe_valid ? mem_rdata : '0;
   assign busy      = (state == BURST) || pipe_any;

endmodule

// File: tb/tb_eeg_sram_port_sched.sv
// Directed bench for eeg_sram_port_sched: vector table for round-robin singles,
// hand sequences for bursts, forced release, stalls, read-back and reset abort.
module tb_eeg_sram_port_sched;

   localparam int N_REQ = 4, AW = 10, DW = 32, RD_LAT = 2, MAX_BURST = 16;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [N_REQ-1:0]    req_valid, req_we, req_last, req_ready, rsp_valid;
   logic [N_REQ*AW-1:0] req_addr;
   logic [N_REQ*DW-1:0] req_wdata;
   logic [DW-1:0]       rsp_rdata, mem_wdata, mem_rdata;
   logic                mem_en, mem_we, busy;
   logic [AW-1:0]       mem_addr;
   logic [1:0]          owner;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [N_REQ-1:0] exp_tag [RD_LAT];
   logic [DW-1:0]    exp_dat [RD_LAT];

   typedef struct {
      logic [3:0] valid, we, last, exp_ready, exp_rsp;
      logic [1:0] exp_owner;
      logic       exp_busy;
   } vec_t;
   vec_t vecs [8];

   eeg_sram_port_sched #(
      .N_REQ(N_REQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
      .req_last(req_last), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] initVal(input int a);
      return 32'h5EED_0000 | a;
   endfunction

   // SRAM macro model with RD_LAT read latency; contents re-seeded during reset.
   logic [DW-1:0] sram [1 << AW];
   logic [DW-1:0] rd_pipe [RD_LAT];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < (1 << AW); i++) sram[i] <= initVal(i);
      end else if (mem_en && mem_we) begin
         sram[mem_addr] <= mem_wdata;
      end
      rd_pipe[0] <= (mem_en && !mem_we) ? sram[mem_addr] : 32'hBAD0_0000;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rdata = rd_pipe[RD_LAT-1];

   function automatic int onehotIdx(input logic [N_REQ-1:0] v);
      int r = -1;
      for (int i = 0; i < N_REQ; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic applyStimulus(input logic [3:0] v, input logic [3:0] we, input logic [3:0] last);
      req_valid = v;
      req_we    = we;
      req_last  = last;
   endtask

   task automatic setReq(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic clearModel();
      for (int i = 0; i < RD_LAT; i++) begin
         exp_tag[i] = '0;
         exp_dat[i] = '0;
      end
   endtask

   // One cycle of a hand sequence: inputs already driven at the negedge.
   task automatic stepCycle(input string name, input logic [N_REQ-1:0] exp_ready, input int exp_busy);
      int idx;
      #1;
      idx = onehotIdx(exp_ready);
      checkOutput({name, " ready"}, req_ready, exp_ready);
      checkOutput({name, " mem_en"}, mem_en, |exp_ready);
      if (idx >= 0) begin
         checkOutput({name, " mem_addr"}, mem_addr, req_addr[idx*AW +: AW]);
         checkOutput({name, " mem_we"}, mem_we, req_we[idx]);
         if (req_we[idx]) checkOutput({name, " mem_wdata"}, mem_wdata, req_wdata[idx*DW +: DW]);
      end
      checkOutput({name, " rsp_valid"}, rsp_valid, exp_tag[RD_LAT-1]);
      if (exp_tag[RD_LAT-1] != '0) checkOutput({name, " rsp_rdata"}, rsp_rdata, exp_dat[RD_LAT-1]);
      if (exp_busy >= 0) checkOutput({name, " busy"}, busy, exp_busy[0]);
      for (int i = RD_LAT - 1; i > 0; i--) begin
         exp_tag[i] = exp_tag[i-1];
         exp_dat[i] = exp_dat[i-1];
      end
      if (idx >= 0 && !req_we[idx]) begin
         exp_tag[0] = exp_ready;
         exp_dat[0] = sram[req_addr[idx*AW +: AW]];
      end else begin
         exp_tag[0] = '0;
         exp_dat[0] = '0;
      end
      @(negedge clk);
   endtask

   initial begin
      int idx;
      rst_n = 1'b0;
      req_addr = '0;
      req_wdata = '0;
      for (int i = 0; i < N_REQ; i++) setReq(i, AW'(10'h100 + i * 16), 32'h0);
      applyStimulus(4'b1111, 4'b0000, 4'b1111);
      clearModel();

      vecs[0] = '{4'b1111, 4'b0000, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0};
      vecs[1] = '{4'b1111, 4'b0000, 4'b1111, 4'b0010, 4'b0000, 2'd0, 1'b1};
      vecs[2] = '{4'b1111, 4'b0000, 4'b1111, 4'b0100, 4'b0001, 2'd1, 1'b1};
      vecs[3] = '{4'b1111, 4'b0000, 4'b1111, 4'b1000, 4'b0010, 2'd2, 1'b1};
      vecs[4] = '{4'b1111, 4'b0000, 4'b1111, 4'b0001, 4'b0100, 2'd3, 1'b1};
      vecs[5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 2'd0, 1'b1};
      vecs[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1};
      vecs[7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};

      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset ready", req_ready, 4'b0000);
      checkOutput("reset mem_en", mem_en, 1'b0);
      checkOutput("reset rsp_valid", rsp_valid, 4'b0000);
      checkOutput("reset rsp_rdata", rsp_rdata, 32'h0);
      checkOutput("reset busy", busy, 1'b0);
      checkOutput("reset owner", owner, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Round-robin single-beat reads from all four requesters.
      for (int r = 0; r < 8; r++) begin
         applyStimulus(vecs[r].valid, vecs[r].we, vecs[r].last);
         #1;
         checkOutput($sformatf("rr%0d ready", r), req_ready, vecs[r].exp_ready);
         checkOutput($sformatf("rr%0d mem_en", r), mem_en, |vecs[r].exp_ready);
         idx = onehotIdx(vecs[r].exp_ready);
         if (idx >= 0) checkOutput($sformatf("rr%0d mem_addr", r), mem_addr, AW'(10'h100 + idx * 16));
         checkOutput($sformatf("rr%0d rsp_valid", r), rsp_valid, vecs[r].exp_rsp);
         idx = onehotIdx(vecs[r].exp_rsp);
         if (idx >= 0) checkOutput($sformatf("rr%0d rsp_rdata", r), rsp_rdata, initVal(10'h100 + idx * 16));
         checkOutput($sformatf("rr%0d owner", r), owner, vecs[r].exp_owner);
         checkOutput($sformatf("rr%0d busy", r), busy, vecs[r].exp_busy);
         @(negedge clk);
      end

      // req1 8-beat write burst while req0/req2 wait; then req2, then req0.
      for (int k = 0; k < 8; k++) begin
         setReq(1, AW'(10'h200 + k), 32'h1000_0000 + k);
         applyStimulus(4'b0111, 4'b0010, (k == 7) ? 4'b0111 : 4'b0101);
         stepCycle($sformatf("burst8 b%0d", k), 4'b0010, (k == 0) ? -1 : 1);
      end
      applyStimulus(4'b0101, 4'b0000, 4'b0101);
      stepCycle("burst8 next", 4'b0100, 0);
      applyStimulus(4'b0001, 4'b0000, 4'b0001);
      stepCycle("burst8 last", 4'b0001, -1);
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      repeat (3) stepCycle("burst8 drain", 4'b0000, -1);

      // req3 20-beat read burst: forced release after 16, req0 served, req3 resumes.
      for (int k = 0; k < 21; k++) begin
         setReq(3, AW'(10'h300 + ((k < 16) ? k : k - 1)), 32'h0);
         if (k < 16) begin
            applyStimulus(4'b1001, 4'b0000, 4'b0001);
            stepCycle($sformatf("force b%0d", k), 4'b1000, -1);
         end else if (k == 16) begin
            applyStimulus(4'b1001, 4'b0000, 4'b0001);
            stepCycle("force req0", 4'b0001, -1);
         end else begin
            applyStimulus(4'b1000, 4'b0000, (k == 20) ? 4'b1000 : 4'b0000);
            stepCycle($sformatf("force b%0d", k - 1), 4'b1000, -1);
         end
      end
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      repeat (3) stepCycle("force drain", 4'b0000, -1);

      // req1 write burst stalls 5 cycles; count must survive the stall.
      setReq(0, 10'h100, 32'h0);
      setReq(2, 10'h120, 32'h0);
      setReq(3, 10'h130, 32'h0);
      for (int k = 0; k < 22; k++) begin
         setReq(1, AW'(10'h380 + k), 32'h2000_0000 + k);
         if (k == 0) begin
            applyStimulus(4'b0010, 4'b0010, 4'b1101);
            stepCycle("stall b0", 4'b0010, -1);
         end else if (k >= 3 && k <= 7) begin
            applyStimulus(4'b1101, 4'b0010, 4'b1101);
            stepCycle($sformatf("stall gap%0d", k), 4'b0000, 1);
         end else if (k < 21) begin
            applyStimulus(4'b1111, 4'b0010, 4'b1101);
            stepCycle($sformatf("stall b%0d", k), 4'b0010, 1);
         end else begin
            applyStimulus(4'b1111, 4'b0010, 4'b1101);
            stepCycle("stall release", 4'b0100, -1);
         end
      end
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      repeat (3) stepCycle("stall drain", 4'b0000, -1);

      // Write 0xA5A5_0001 to 0x3FF by req2, read back by req0.
      setReq(2, 10'h3FF, 32'hA5A5_0001);
      setReq(0, 10'h3FF, 32'h0);
      applyStimulus(4'b0100, 4'b0100, 4'b1111);
      stepCycle("rb write", 4'b0100, -1);
      applyStimulus(4'b0001, 4'b0000, 4'b1111);
      stepCycle("rb read", 4'b0001, -1);
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      stepCycle("rb wait", 4'b0000, -1);
      #1;
      checkOutput("rb rsp_valid", rsp_valid, 4'b0001);
      checkOutput("rb rsp_rdata", rsp_rdata, 32'hA5A5_0001);
      stepCycle("rb done", 4'b0000, -1);

      // Reset during a read burst with two reads in flight.
      setReq(1, 10'h050, 32'h0);
      applyStimulus(4'b0010, 4'b0000, 4'b0000);
      stepCycle("rst b0", 4'b0010, -1);
      applyStimulus(4'b1111, 4'b0000, 4'b1101);
      stepCycle("rst b1", 4'b0010, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst ready", req_ready, 4'b0000);
      checkOutput("rst mem_en", mem_en, 1'b0);
      checkOutput("rst mem_addr", mem_addr, 10'h0);
      checkOutput("rst rsp_valid", rsp_valid, 4'b0000);
      checkOutput("rst rsp_rdata", rsp_rdata, 32'h0);
      checkOutput("rst busy", busy, 1'b0);
      checkOutput("rst owner", owner, 2'd0);
      clearModel();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      repeat (3) stepCycle("post-rst quiet", 4'b0000, 0);
      applyStimulus(4'b1111, 4'b0000, 4'b1111);
      stepCycle("post-rst grant", 4'b0001, 0);
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      repeat (3) stepCycle("post-rst drain", 4'b0000, -1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
